// File: rtl/ahb_burst_feeder.sv
// ahb_burst_feeder: takes one burst command at a time and drives the
// ahb_master user interface (UI).
// Write bursts pull beats from a valid/ready source.
// Read bursts collect returned data into a registered stream that has no
// backpressure.
// UI registers change only on m_next edges, except for the first
// presentation of a burst.
// Ports:
//   i_hclk, i_hreset        clock, async active-high reset
//   i_cmd_*/o_cmd_ready     command handshake (addr, len, write, size, prot, lock)
//   i_wr_valid/o_wr_ready/i_wr_data   write-data source
//   o_rd_valid/o_rd_data/o_rd_addr    read-return stream
//   o_done                  one-cycle completion pulse
//   m_* out                 master UI drive (addr/size/write/read/min_len/cont/valid/data/prot/lock)
//   m_next, m_ready, m_rdata, m_raddr  master UI feedback
module ahb_burst_feeder #(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [31:0]         i_cmd_addr,
  input  logic [BEAT_WDT-1:0] i_cmd_len,
  input  logic                i_cmd_write,
  input  logic [2:0]          i_cmd_size,
  input  logic [3:0]          i_cmd_prot,
  input  logic                i_cmd_lock,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [DATA_WDT-1:0] i_wr_data,
  output logic                o_rd_valid,
  output logic [DATA_WDT-1:0] o_rd_data,
  output logic [31:0]         o_rd_addr,
  output logic                o_done,
  output logic [31:0]         m_addr,
  output logic [2:0]          m_size,
  output logic                m_write,
  output logic                m_read,
  output logic [BEAT_WDT-1:0] m_min_len,
  output logic                m_cont,
  output logic                m_valid,
  output logic [DATA_WDT-1:0] m_data,
  output logic [3:0]          m_prot,
  output logic                m_lock,
  input  logic                m_next,
  input  logic                m_ready,
  input  logic [DATA_WDT-1:0] m_rdata,
  input  logic [31:0]         m_raddr
);

  typedef enum logic [2:0] {IDLE, WAIT_W0, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic                is_write;
  logic [31:0]         addr;
  logic [BEAT_WDT-1:0] len, pending, returned;
  logic [BEAT_WDT-1:0] pend_sub, returned_nx;
  logic                last, rd_take;

  always_comb begin
    // A write beat only counts when it carried data; BUSY beats leave pending alone.
    pend_sub    = pending - (is_write ? BEAT_WDT'(m_valid) : BEAT_WDT'(1));
    last        = (pend_sub == '0);
    // is_write/len/returned are all cleared at reset, so nothing is counted
    // before the first read command is accepted.
    rd_take     = !is_write && m_ready && (returned < len);
    returned_nx = returned + BEAT_WDT'(rd_take);
    o_cmd_ready = (state == IDLE);
    o_done      = (state == DONE);
    o_wr_ready  = 1'b0;
    state_nx    = state;
    case (state)
      IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_len == '0)  state_nx = DONE;
          else if (i_cmd_write) state_nx = WAIT_W0;
          else                  state_nx = ISSUE;
        end
      end
      WAIT_W0: begin
        o_wr_ready = 1'b1;
        if (i_wr_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        if (is_write) o_wr_ready = m_next && !last;
        if (m_next && last) state_nx = is_write ? DONE : DRAIN;
      end
      DRAIN: begin
        if (returned_nx == len) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      addr       <= '0;
      len        <= '0;
      pending    <= '0;
      returned   <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_addr  <= '0;
      m_addr     <= '0;
      m_size     <= '0;
      m_write    <= 1'b0;
      m_read     <= 1'b0;
      m_min_len  <= '0;
      m_cont     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_prot     <= '0;
      m_lock     <= 1'b0;
    end else begin
      state      <= state_nx;
      returned   <= returned_nx;
      o_rd_valid <= rd_take;
      if (rd_take) begin
        o_rd_data <= m_rdata;
        o_rd_addr <= m_raddr;
      end
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            is_write <= i_cmd_write;
            len      <= i_cmd_len;
            pending  <= i_cmd_len;
            returned <= '0;
            addr     <= i_cmd_addr;
            if (i_cmd_len != '0) begin
              m_size <= i_cmd_size;
              m_prot <= i_cmd_prot;
              m_lock <= i_cmd_lock;
              if (!i_cmd_write) begin
                m_read    <= 1'b1;
                m_cont    <= 1'b0;
                m_addr    <= i_cmd_addr;
                m_min_len <= i_cmd_len;
              end
            end
          end
        end
        WAIT_W0: begin
          if (i_wr_valid) begin
            m_write   <= 1'b1;
            m_cont    <= 1'b0;
            m_valid   <= 1'b1;
            m_data    <= i_wr_data;
            m_addr    <= addr;
            m_min_len <= len;
          end
        end
        ISSUE: begin
          if (m_next) begin
            pending <= pend_sub;
            if (last) begin
              m_write <= 1'b0;
              m_read  <= 1'b0;
              m_cont  <= 1'b0;
              m_valid <= 1'b0;
            end else begin
              m_cont <= 1'b1;
              if (is_write) begin
                m_valid <= i_wr_valid;
                m_data  <= i_wr_data;
              end
            end
          end
        end
        DONE: begin
          m_addr    <= '0;
          m_size    <= '0;
          m_min_len <= '0;
          m_data    <= '0;
          m_prot    <= '0;
          m_lock    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_feeder.sv
// Directed bench for ahb_burst_feeder. It checks reset state, write bursts
// (streaming and with a BUSY beat), a read burst with a surplus return,
// a zero-length command, a reset in the middle of a burst, and back-to-back
// commands.
module tb_ahb_burst_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid, o_cmd_ready;
  logic [31:0] i_cmd_addr, i_cmd_len;
  logic        i_cmd_write;
  logic [2:0]  i_cmd_size;
  logic [3:0]  i_cmd_prot;
  logic        i_cmd_lock;
  logic        i_wr_valid, o_wr_ready;
  logic [31:0] i_wr_data;
  logic        o_rd_valid;
  logic [31:0] o_rd_data, o_rd_addr;
  logic        o_done;
  logic [31:0] m_addr, m_min_len, m_data;
  logic [2:0]  m_size;
  logic        m_write, m_read, m_cont, m_valid, m_lock;
  logic [3:0]  m_prot;
  logic        m_next, m_ready;
  logic [31:0] m_rdata, m_raddr;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int dones = 0;
  int p0, d0;
  logic seen;

  // Write burst with one stall: per-cycle inputs and expected UI state while in ISSUE.
  logic [31:0] t2_wd [4] = '{32'hEE, 32'h22, 32'h33, 32'h0};
  logic        t2_wv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic        t2_mv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] t2_md [4] = '{32'h11, 32'h0, 32'h22, 32'h33};
  logic        t2_cn [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic        t2_wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // Read burst, len=3 at 0x100: inputs per cycle and expectations at that cycle.
  logic        t3_nx [8] = '{0, 1, 0, 1, 1, 0, 0, 0};
  logic        t3_rd [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
  logic [31:0] t3_dt [8] = '{0, 0, 32'hA, 32'hB, 0, 32'hC, 32'hD, 0};
  logic [31:0] t3_ad [8] = '{0, 0, 32'h100, 32'h104, 0, 32'h108, 32'h10C, 0};
  logic        t3_rv [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
  logic [31:0] t3_ed [8] = '{0, 0, 0, 32'hA, 32'hB, 0, 32'hC, 0};
  logic [31:0] t3_ea [8] = '{0, 0, 0, 32'h100, 32'h104, 0, 32'h108, 0};
  logic        t3_dn [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic        t3_mr [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  logic        t3_mc [8] = '{0, 0, 1, 1, 1, 0, 0, 0};

  ahb_burst_feeder #(.DATA_WDT(32), .BEAT_WDT(32)) dut (
    .i_hclk(clk), .i_hreset(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len), .i_cmd_write(i_cmd_write),
    .i_cmd_size(i_cmd_size), .i_cmd_prot(i_cmd_prot), .i_cmd_lock(i_cmd_lock),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr),
    .o_done(o_done),
    .m_addr(m_addr), .m_size(m_size), .m_write(m_write), .m_read(m_read),
    .m_min_len(m_min_len), .m_cont(m_cont), .m_valid(m_valid), .m_data(m_data),
    .m_prot(m_prot), .m_lock(m_lock),
    .m_next(m_next), .m_ready(m_ready), .m_rdata(m_rdata), .m_raddr(m_raddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (o_wr_ready && i_wr_valid) pops = pops + 1;
      if (o_done) dones = dones + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] a, input logic [31:0] n,
                         input logic [2:0] sz, input logic [3:0] pr, input logic lk);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_len   = n;
    i_cmd_size  = sz;
    i_cmd_prot  = pr;
    i_cmd_lock  = lk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_cmd_valid = 0; i_cmd_addr = 0; i_cmd_len = 0; i_cmd_write = 0;
    i_cmd_size = 0; i_cmd_prot = 0; i_cmd_lock = 0;
    i_wr_valid = 0; i_wr_data = 0; m_next = 0; m_ready = 0; m_rdata = 0; m_raddr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_addr", m_addr, 0);
    rst = 1'b0;

    // Write len=4, always-valid data, m_next every cycle.
    p0 = pops; d0 = dones;
    set_cmd(1, 32'h40, 4, 3'd2, 4'd3, 1'b0);
    m_next = 1;
    #1 chk("t1_cmd_ready", o_cmd_ready, 1);
    cyc;
    i_cmd_valid = 0; i_wr_valid = 1; i_wr_data = 1;
    #1;
    chk("t1_w0_wr_ready", o_wr_ready, 1);
    chk("t1_w0_cmd_ready", o_cmd_ready, 0);
    chk("t1_w0_m_write", m_write, 0);
    chk("t1_size", m_size, 2);
    chk("t1_prot", m_prot, 3);
    cyc;
    chk("t1_addr", m_addr, 32'h40);
    chk("t1_min_len", m_min_len, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_m_write", m_write, 1);
      chk("t1_m_cont", m_cont, k != 0);
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_data", m_data, k + 1);
      i_wr_data = k + 2;
      #1 chk("t1_wr_ready", o_wr_ready, k < 3);
      cyc;
    end
    i_wr_valid = 0;
    chk("t1_m_write_drop", m_write, 0);
    chk("t1_done", o_done, 1);
    cyc;
    chk("t1_done_end", o_done, 0);
    chk("t1_cmd_ready_back", o_cmd_ready, 1);
    chk("t1_size_idle", m_size, 0);
    chk("t1_pops", pops - p0, 4);
    chk("t1_done_cnt", dones - d0, 1);

    // Write len=3 with a stalled source: one BUSY beat in the middle.
    p0 = pops; d0 = dones;
    set_cmd(1, 32'h80, 3, 3'd2, 4'd0, 1'b0);
    cyc;
    i_cmd_valid = 0; i_wr_valid = 1; i_wr_data = 32'h11;
    cyc;
    for (int k = 0; k < 4; k++) begin
      chk("t2_m_write", m_write, 1);
      chk("t2_m_valid", m_valid, t2_mv[k]);
      chk("t2_m_cont", m_cont, t2_cn[k]);
      if (t2_mv[k]) chk("t2_m_data", m_data, t2_md[k]);
      i_wr_valid = t2_wv[k]; i_wr_data = t2_wd[k];
      #1 chk("t2_wr_ready", o_wr_ready, t2_wr[k]);
      cyc;
    end
    i_wr_valid = 0;
    chk("t2_m_write_drop", m_write, 0);
    chk("t2_done", o_done, 1);
    cyc;
    chk("t2_pops", pops - p0, 3);
    chk("t2_done_cnt", dones - d0, 1);

    // Read len=3 at 0x100, irregular m_next, one surplus m_ready.
    d0 = dones;
    set_cmd(0, 32'h100, 3, 3'd2, 4'hA, 1'b1);
    m_next = 0;
    cyc;
    i_cmd_valid = 0;
    chk("t3_addr", m_addr, 32'h100);
    chk("t3_min_len", m_min_len, 3);
    chk("t3_lock", m_lock, 1);
    chk("t3_prot", m_prot, 4'hA);
    chk("t3_m_write", m_write, 0);
    for (int c = 0; c < 8; c++) begin
      chk("t3_rd_valid", o_rd_valid, t3_rv[c]);
      if (t3_rv[c]) begin
        chk("t3_rd_data", o_rd_data, t3_ed[c]);
        chk("t3_rd_addr", o_rd_addr, t3_ea[c]);
      end
      chk("t3_done", o_done, t3_dn[c]);
      chk("t3_m_read", m_read, t3_mr[c]);
      chk("t3_m_cont", m_cont, t3_mc[c]);
      m_next = t3_nx[c]; m_ready = t3_rd[c]; m_rdata = t3_dt[c]; m_raddr = t3_ad[c];
      cyc;
    end
    m_ready = 0;
    chk("t3_done_cnt", dones - d0, 1);

    // Zero-length command: no UI activity, immediate completion.
    set_cmd(1, 32'h300, 0, 3'd2, 4'd1, 1'b1);
    cyc;
    i_cmd_valid = 0;
    #1;
    chk("t4_done", o_done, 1);
    chk("t4_cmd_ready", o_cmd_ready, 0);
    chk("t4_wr_ready", o_wr_ready, 0);
    chk("t4_m_write", m_write, 0);
    chk("t4_m_addr", m_addr, 0);
    chk("t4_m_size", m_size, 0);
    cyc;
    chk("t4_done_end", o_done, 0);
    chk("t4_cmd_ready_back", o_cmd_ready, 1);

    // Reset partway through a len=5 write, then a clean read of len=2.
    d0 = dones;
    set_cmd(1, 32'h500, 5, 3'd2, 4'd2, 1'b0);
    m_next = 1;
    cyc;
    i_cmd_valid = 0; i_wr_valid = 1; i_wr_data = 1;
    cyc;
    i_wr_data = 2;
    cyc;
    chk("t5_pre_data", m_data, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_m_write", m_write, 0);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_m_addr", m_addr, 0);
    chk("t5_m_size", m_size, 0);
    chk("t5_cmd_ready", o_cmd_ready, 1);
    chk("t5_wr_ready", o_wr_ready, 0);
    i_wr_valid = 0;
    cyc;
    cyc;
    rst = 1'b0;
    chk("t5_no_done", dones - d0, 0);
    set_cmd(0, 32'h200, 2, 3'd2, 4'd0, 1'b0);
    cyc;
    i_cmd_valid = 0;
    chk("t5r_m_read", m_read, 1);
    chk("t5r_m_cont", m_cont, 0);
    chk("t5r_addr", m_addr, 32'h200);
    cyc;
    chk("t5r_m_cont1", m_cont, 1);
    m_ready = 1; m_rdata = 32'h55; m_raddr = 32'h200;
    cyc;
    chk("t5r_m_read_drop", m_read, 0);
    chk("t5r_rd_valid0", o_rd_valid, 1);
    chk("t5r_rd_data0", o_rd_data, 32'h55);
    m_rdata = 32'h66; m_raddr = 32'h204;
    cyc;
    m_ready = 0;
    chk("t5r_done", o_done, 1);
    chk("t5r_rd_data1", o_rd_data, 32'h66);
    chk("t5r_rd_addr1", o_rd_addr, 32'h204);
    cyc;
    chk("t5r_done_end", o_done, 0);
    chk("t5r_rd_valid_end", o_rd_valid, 0);
    chk("t5_done_cnt", dones - d0, 1);

    // Back-to-back: write len=2, then a read len=2 held valid throughout.
    p0 = pops; d0 = dones;
    set_cmd(1, 32'h600, 2, 3'd2, 4'd0, 1'b0);
    cyc;
    set_cmd(0, 32'h700, 2, 3'd1, 4'd0, 1'b0);
    i_wr_valid = 1; i_wr_data = 7;
    #1 chk("t6_w0_cmd_ready", o_cmd_ready, 0);
    cyc;
    chk("t6_m_cont0", m_cont, 0);
    chk("t6_m_data0", m_data, 7);
    i_wr_data = 8;
    cyc;
    chk("t6_m_cont1", m_cont, 1);
    chk("t6_m_data1", m_data, 8);
    #1 chk("t6_wr_ready_last", o_wr_ready, 0);
    cyc;
    i_wr_valid = 0;
    chk("t6_done", o_done, 1);
    chk("t6_done_cmd_ready", o_cmd_ready, 0);
    chk("t6_done_m_read", m_read, 0);
    cyc;
    chk("t6_idle_cmd_ready", o_cmd_ready, 1);
    chk("t6_idle_m_read", m_read, 0);
    cyc;
    i_cmd_valid = 0;
    chk("t6r_m_read", m_read, 1);
    chk("t6r_m_cont", m_cont, 0);
    chk("t6r_addr", m_addr, 32'h700);
    chk("t6r_min_len", m_min_len, 2);
    chk("t6r_size", m_size, 1);
    m_ready = 1; m_rdata = 32'h77; m_raddr = 32'h700;
    cyc;
    m_rdata = 32'h88; m_raddr = 32'h704;
    cyc;
    m_ready = 0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (o_done) seen = 1;
      else cyc;
    end
    chk("t6_read_done_seen", seen, 1);
    chk("t6_pops", pops - p0, 2);
    cyc;
    chk("t6_done_cnt", dones - d0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_burst_feeder.md
# ahb_burst_feeder

Command-driven sequencer sitting directly upstream of `ahb_master`'s user interface (UI). It accepts one burst command at a time, streams write beats from a FIFO-style source, and collects read returns into a registered output stream. It drives `i_addr/i_write/i_read/i_cont/i_valid/i_data/i_min_len` of the master only on `o_next` edges, honouring the master's UI change rules.

## Interface
Parameters:
- DATA_WDT, 32, data width (matches master)
- BEAT_WDT, 32, beat-count width (matches master `i_min_len`)

Ports:
- i_hclk  in  1  clock
- i_hreset  in  1  asynchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_addr  in  32  burst base address
- i_cmd_len  in  BEAT_WDT  beat count
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_size, i_cmd_prot, i_cmd_lock  in  3/4/1  forwarded as HSIZE/HPROT/HLOCK
- i_wr_valid / o_wr_ready / i_wr_data  in/out/in  1/1/DATA_WDT  write-data stream
- o_rd_valid / o_rd_data / o_rd_addr  out  1/DATA_WDT/32  read-return stream, no backpressure
- o_done  out  1  one-cycle completion pulse
- To master: m_addr 32, m_size 3, m_write 1, m_read 1, m_min_len BEAT_WDT, m_cont 1, m_valid 1, m_data DATA_WDT, m_prot 4, m_lock 1 (out); m_next, m_ready 1, m_rdata DATA_WDT, m_raddr 32 (in). These connect to the master's i_*/o_* UI.

## Operation
- States: IDLE, WAIT_W0, ISSUE, DRAIN, DONE.
- IDLE: o_cmd_ready=1. On i_cmd_valid, latch command; pending=len, returned=0.
  - len==0 → DONE; UI untouched.
  - write → WAIT_W0.
  - read → ISSUE, presenting m_read=1, m_cont=0, m_addr, m_min_len=len.
- WAIT_W0: o_wr_ready=1. When i_wr_valid is set, register the first beat: m_write=1, m_cont=0, m_valid=1, m_data=i_wr_data, m_addr, m_min_len=len. Go to ISSUE. The first write UI always carries valid data.
- ISSUE: UI registers change only at an edge where m_next=1.
  - Write: new = pending − m_valid(presented).
  - Read: new = pending − 1.
  - new==0: drive m_write=m_read=m_cont=m_valid=0. Write → DONE; read → DRAIN.
  - new>0: m_cont=1.
    - Write: o_wr_ready = m_next (combinational). m_valid ← i_wr_valid, m_data ← i_wr_data.
    - Read: UI held.
  - m_valid=0 presents a BUSY beat. It is not counted, and is re-sampled at the next m_next edge.
- m_prot, m_lock, m_size hold the latched values while busy and are 0 in IDLE.
- Read return (any state after a read accept): each m_ready=1 with returned<len → next-cycle o_rd_valid=1, o_rd_data=m_rdata, o_rd_addr=m_raddr, returned++. m_ready beyond len or during writes is ignored.
- DRAIN: when returned==len (checked after update) → DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Write completion means all beats were accepted by the master, not that the bus transfer finished.
- Reset mid-burst: command abandoned, all state cleared, no o_done.

## Timing
- Reset values: o_cmd_ready=1; o_wr_ready=0; o_rd_valid=0; o_done=0; all m_* and o_rd_data/o_rd_addr = 0.
- Command accept to first UI:
  - read: 1 cycle.
  - write: ≥2 cycles (WAIT_W0 is at least 1 cycle).
- o_done: 1 cycle after the final m_next edge (write), or 1 cycle after the edge that registers the last read return.
- o_rd_valid: 1-cycle latency from m_ready; never stalls.
- o_cmd_ready is low from the accept edge until after the DONE cycle. The minimum command-to-command gap is the DONE cycle plus IDLE.
- Counters are BEAT_WDT wide and never wrap, since they are bounded by len.

## Test plan
- Write, len=4, data 1..4 always valid, m_next=1 every cycle → UI shows m_cont 0,1,1,1 with data 1,2,3,4. m_write drops after the 4th m_next edge; o_done pulses 1 cycle later; exactly 4 o_wr_ready pops.
- Write, len=3, i_wr_valid pattern 1,0,1,1 → one BUSY beat (m_valid=0) is presented and not counted. Exactly 3 valid beats with data in order; o_done once.
- Read, len=3, addr 0x100, random m_next; m_ready returns 0xA,0xB,0xC plus one extra pulse → o_rd_valid ×3 with matching data and addr; extra pulse ignored; o_done after the 3rd return.
- len=0 command → no UI activity; o_done 1 cycle after accept; o_cmd_ready high again the following cycle.
- Reset asserted mid-write after 2 of 5 beats → all outputs return to reset values asynchronously; no o_done; a subsequent read of len=2 completes normally.
- Back-to-back write(len=2) then read(len=2) commands held valid → second command accepted only in the IDLE cycle after the first o_done; first UI of the second burst has m_cont=0.
